// File: rtl/decoder_fixed_point_seq.sv
// Sequential fixed-point decoder layer: out[j] = b[j] + sum_i x[i]*w[j][i],
// computed by one shared multiply-accumulate unit, valid/ready on both sides.

module fxp_mul #(
   parameter int BITSIZE   = 32,
   parameter int FRAC_BITS = 16
) (
   input  logic [BITSIZE-1:0] a,
   input  logic [BITSIZE-1:0] b,
   output logic [BITSIZE-1:0] p
);
   logic signed [2*BITSIZE-1:0] full;

   assign full = $signed({{BITSIZE{a[BITSIZE-1]}}, a}) * $signed({{BITSIZE{b[BITSIZE-1]}}, b});
   // Arithmetic shift floors toward -inf; the low word is kept with no saturation.
   assign p = BITSIZE'(full >>> FRAC_BITS);
endmodule

module decoder_fixed_point_seq #(
   parameter int N_input   = 4,
   parameter int M_output  = 9,
   parameter int BITSIZE   = 32,
   parameter int FRAC_BITS = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [N_input*BITSIZE-1:0]            x,
   input  logic [N_input*M_output*BITSIZE-1:0]   w,
   input  logic [M_output*BITSIZE-1:0]           b,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [M_output*BITSIZE-1:0]           out
);
   localparam int IW = (N_input > 1) ? $clog2(N_input) : 1;
   localparam int JW = (M_output > 1) ? $clog2(M_output) : 1;
   localparam int KW = (N_input*M_output > 1) ? $clog2(N_input*M_output) : 1;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   typedef struct packed {
      logic [M_output-1:0][BITSIZE-1:0]         b;
      logic [M_output*N_input-1:0][BITSIZE-1:0] w;
      logic [N_input-1:0][BITSIZE-1:0]          x;
   } vec_t;

   state_t                            state, state_nxt;
   vec_t                              vec;
   logic [IW-1:0]                     i;
   logic [JW-1:0]                     j, jn;
   logic [KW-1:0]                     k;
   logic [BITSIZE-1:0]                acc, p, s;
   logic [M_output-1:0][BITSIZE-1:0]  out_q;
   logic                              accept, last_i, last_j;

   // k walks the weight array linearly, so it always equals j*N_input+i.
   fxp_mul #(.BITSIZE(BITSIZE), .FRAC_BITS(FRAC_BITS)) u_mul (
      .a (vec.x[i]),
      .b (vec.w[k]),
      .p (p)
   );

   assign s        = acc + p;
   assign in_ready = (state == IDLE) & ~rst;
   assign accept   = in_valid & in_ready;
   assign last_i   = (i == IW'(N_input-1));
   assign last_j   = (j == JW'(M_output-1));
   assign jn       = last_j ? '0 : j + 1'b1;
   assign out      = out_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = MAC;
         MAC:     if (last_i && last_j) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_q     <= '0;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  vec <= '{b: b, w: w, x: x};
                  i   <= '0;
                  j   <= '0;
                  k   <= '0;
                  acc <= b[BITSIZE-1:0];
               end
            end
            MAC: begin
               k <= k + 1'b1;
               if (!last_i) begin
                  acc <= s;
                  i   <= i + 1'b1;
               end else begin
                  out_q[j] <= s;
                  i        <= '0;
                  // Preload the next row's bias; the value after the last row is unused.
                  acc      <= vec.b[jn];
                  if (last_j) out_valid <= 1'b1;
                  else        j <= j + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_decoder_fixed_point_seq.sv
// Directed bench for decoder_fixed_point_seq: hand-computed vectors plus a
// small reference model for the randomised vectors.

module tb_decoder_fixed_point_seq;
   localparam int N = 4;
   localparam int M = 9;
   localparam int BS = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [N*BS-1:0]   x;
   logic [N*M*BS-1:0] w;
   logic [M*BS-1:0]   b;
   logic              out_valid;
   logic              out_ready;
   logic [M*BS-1:0]   dout;

   logic [31:0] xa [N];
   logic [31:0] wa [M][N];
   logic [31:0] ba [M];
   logic [31:0] exp_o [M];

   int n_checks = 0;
   int n_fail   = 0;
   int lat;
   int highs;

   decoder_fixed_point_seq #(.N_input(N), .M_output(M), .BITSIZE(BS), .FRAC_BITS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .w         (w),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] word(input int j);
      return dout[j*BS +: BS];
   endfunction

   task automatic pack();
      for (int i = 0; i < N; i++) x[i*BS +: BS] = xa[i];
      for (int j = 0; j < M; j++) begin
         b[j*BS +: BS] = ba[j];
         for (int i = 0; i < N; i++) w[(j*N+i)*BS +: BS] = wa[j][i];
      end
   endtask

   task automatic model();
      logic signed [63:0] pr;
      logic [31:0]        s;
      for (int j = 0; j < M; j++) begin
         s = ba[j];
         for (int i = 0; i < N; i++) begin
            pr = $signed({{32{xa[i][31]}}, xa[i]}) * $signed({{32{wa[j][i][31]}}, wa[j][i]});
            s  = s + pr[47:16];
         end
         exp_o[j] = s;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge with inputs scrambled.
   task automatic accept_vec();
      pack();
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      x = {N{$urandom()}};
      w = {(N*M){$urandom()}};
      b = {M{$urandom()}};
   endtask

   task automatic wait_out(input string tag);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({tag, " latency"}, 32'(lat), 32'd36);
      for (int j = 0; j < M; j++) chk($sformatf("%s out[%0d]", tag, j), word(j), exp_o[j]);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " out_valid after xfer"}, {31'd0, out_valid}, 32'd0);
      chk({tag, " in_ready after xfer"}, {31'd0, in_ready}, 32'd1);
      chk({tag, " out held after xfer"}, word(M-1), exp_o[M-1]);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      x = '0; w = '0; b = '0;

      // 1: reset
      @(negedge clk);
      chk("in_ready during rst", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("in_ready during rst 2", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
      for (int j = 0; j < M; j++) chk($sformatf("reset out[%0d]", j), word(j), 32'd0);
      @(negedge clk);

      // 2: zero weights, bias only
      xa = '{32'h12345678, 32'hDEADBEEF, 32'h00010000, 32'h80000000};
      for (int j = 0; j < M; j++) begin
         ba[j] = 32'(j) << 16;
         exp_o[j] = 32'(j) << 16;
         for (int i = 0; i < N; i++) wa[j][i] = 32'd0;
      end
      accept_vec();
      chk("t2 in_ready busy", {31'd0, in_ready}, 32'd0);
      wait_out("t2");
      handshake("t2");

      // 3: x = 1..4, all w = 1.0, b = 0 -> 10.0
      xa = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000};
      for (int j = 0; j < M; j++) begin
         ba[j] = 32'd0;
         exp_o[j] = 32'h000A0000;
         for (int i = 0; i < N; i++) wa[j][i] = 32'h00010000;
      end
      accept_vec();
      wait_out("t3");
      handshake("t3");

      // 4: only w[j][0] = 0.5; floor behaviour of the product
      for (int j = 0; j < M; j++) begin
         ba[j] = 32'd0;
         wa[j][0] = 32'h00008000;
         for (int i = 1; i < N; i++) wa[j][i] = 32'd0;
      end
      xa = '{32'hFFFE8000, 32'h7FFFFFFF, 32'h00050000, 32'hFFFFFFFF};
      for (int j = 0; j < M; j++) exp_o[j] = 32'hFFFF4000;
      accept_vec();
      wait_out("t4a");
      handshake("t4a");
      xa[0] = 32'h00000001;
      for (int j = 0; j < M; j++) exp_o[j] = 32'h00000000;
      accept_vec();
      wait_out("t4b");
      handshake("t4b");
      xa[0] = 32'hFFFFFFFF;
      for (int j = 0; j < M; j++) exp_o[j] = 32'hFFFFFFFF;
      accept_vec();
      wait_out("t4c");
      handshake("t4c");

      // 5: backpressure with in_valid held high in DONE
      for (int i = 0; i < N; i++) xa[i] = $urandom();
      for (int j = 0; j < M; j++) begin
         ba[j] = $urandom();
         for (int i = 0; i < N; i++) wa[j][i] = $urandom();
      end
      model();
      accept_vec();
      wait_out("t5");
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         x = {N{$urandom()}};
         @(posedge clk);
         @(negedge clk);
         chk("t5 out_valid held", {31'd0, out_valid}, 32'd1);
         chk("t5 in_ready low", {31'd0, in_ready}, 32'd0);
         chk($sformatf("t5 out[%0d] stable", c % M), word(c % M), exp_o[c % M]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("t5 out_valid after xfer", {31'd0, out_valid}, 32'd0);
      chk("t5 in_ready after xfer", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < N; i++) xa[i] = $urandom();
      for (int j = 0; j < M; j++) begin
         ba[j] = $urandom();
         for (int i = 0; i < N; i++) wa[j][i] = $urandom();
      end
      model();
      accept_vec();
      wait_out("t5 next");
      handshake("t5 next");

      // 6: reset on the 20th MAC edge aborts the vector
      accept_vec();
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6 out_valid after abort", {31'd0, out_valid}, 32'd0);
      chk("t6 in_ready after abort", {31'd0, in_ready}, 32'd1);
      for (int j = 0; j < M; j++) chk($sformatf("t6 out[%0d] cleared", j), word(j), 32'd0);
      highs = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) highs++;
      end
      chk("t6 no out_valid pulse", 32'(highs), 32'd0);
      accept_vec();
      wait_out("t6 next");
      handshake("t6 next");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
